// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Bundle between the multicycle MIPS control unit and its datapath.
//   Datapath -> control : op, funct (instruction register fields), zero (ALU)
//   Control -> datapath : PC/IR/regfile/memory enables, mux selects,
//                         ALU operation, illegal pulse, debug state
// Modports:
//   master : the controller (drives all enables and selects)
//   slave  : the datapath (drives op, funct, zero)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
               memtoreg, regdst, pcsrc, alucontrol, illegal, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
               memtoreg, regdst, pcsrc, alucontrol, illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Moore control FSM plus ALU decoder for the multicycle MIPS datapath
// (shared instruction/data memory, single ALU). Supports lw, sw, R-type
// (add, sub, and, or, slt), beq, addi and j; anything else pulses illegal
// in DECODE and returns to FETCH.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset; clears state to FETCH and
//            combinationally blocks every write enable and illegal
//   bus    : multicycle_controller_if.master (op/funct/zero in, controls out)
//
// state | meaning
// ------+---------------------------------------------------------
//   0   | FETCH    : IR <- mem[PC], PC <- PC + 4
//   1   | DECODE   : ALUOut <- PC + (imm << 2) (branch target), dispatch
//   2   | MEMADR   : ALUOut <- A + sign-extended imm
//   3   | MEMREAD  : read mem[ALUOut]
//   4   | MEMWB    : rt <- memory data
//   5   | MEMWRITE : mem[ALUOut] <- B
//   6   | EXECUTE  : ALUOut <- A op B
//   7   | ALUWB    : rd <- ALUOut
//   8   | BRANCH   : PC <- ALUOut when A == B
//   9   | ADDIEX   : ALUOut <- A + sign-extended imm
//  10   | ADDIWB   : rt <- ALUOut
//  11   | JUMP     : PC <- jump target
// 12-15 | unused   : no enables, return to FETCH
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module multicycle_controller #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_controller_if.master   bus
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEX   = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    logic [3:0] state_q, state_d;

    logic       funct_ok;
    logic       op_ok;
    logic       pcwrite;
    logic       branch;
    logic       irwrite_raw;
    logic       regwrite_raw;
    logic       memwrite_raw;
    logic       illegal_raw;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        funct_ok = 1'b0;
        case (bus.funct)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: funct_ok = 1'b1;
            default:                          funct_ok = 1'b0;
        endcase
    end

    // An R-type with an unknown funct is rejected at DECODE just like an
    // unknown opcode, so EXECUTE never sees an unsupported operation.
    always_comb begin
        op_ok = 1'b0;
        case (bus.op)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
            OP_RTYPE:                            op_ok = funct_ok;
            default:                             op_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_ok ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (bus.op == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        aluop        = 2'b00;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        pcsrc        = 2'b00;
        case (state_q)
            S_FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
            end
            S_DECODE: begin
                alusrcb     = 2'b11;
                illegal_raw = ~op_ok;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMREAD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWRITE: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (bus.funct)
                    F_ADD:   alucontrol = 3'b010;
                    F_SUB:   alucontrol = 3'b110;
                    F_AND:   alucontrol = 3'b000;
                    F_OR:    alucontrol = 3'b001;
                    F_SLT:   alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // Enables are gated by reset itself so a mid-instruction reset cannot
    // leave a partial register or memory write in flight.
    assign bus.pcen       = reset & (pcwrite | (branch & bus.zero));
    assign bus.irwrite    = reset & irwrite_raw;
    assign bus.regwrite   = reset & regwrite_raw;
    assign bus.memwrite   = reset & memwrite_raw;
    assign bus.illegal    = reset & illegal_raw;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.iord       = iord;
    assign bus.memtoreg   = memtoreg;
    assign bus.regdst     = regdst;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = alucontrol;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps

module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;

    multicycle_controller_if bus_if ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    int m_idx  = 0;

    // Output vector layout
    localparam int B_PCEN = 15, B_MEMW = 14, B_IRW = 13, B_REGW = 12, B_SRCA = 11;
    localparam int B_SRCB = 9, B_IORD = 8, B_M2R = 7, B_RDST = 6, B_PCSRC = 4;
    localparam int B_ALU = 1, B_ILL = 0;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_ILL = 6;

    int          rec_n;
    int          rec_state [8];
    logic [15:0] rec_out   [8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int instr_class(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b001000: return C_ADDI;
            6'b000010: return C_J;
            6'b000000: begin
                if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a)
                    return C_R;
                return C_ILL;
            end
            default:   return C_ILL;
        endcase
    endfunction

    // State visited at step k of an instruction of the given class
    function automatic int path_state(input int cls, input int k);
        int lw_p [5] = '{0, 1, 2, 3, 4};
        int sw_p [4] = '{0, 1, 2, 5};
        int r_p  [4] = '{0, 1, 6, 7};
        int bq_p [3] = '{0, 1, 8};
        int ad_p [4] = '{0, 1, 9, 10};
        int j_p  [3] = '{0, 1, 11};
        case (cls)
            C_LW:   return lw_p[k];
            C_SW:   return sw_p[k];
            C_R:    return r_p[k];
            C_BEQ:  return bq_p[k];
            C_ADDI: return ad_p[k];
            C_J:    return j_p[k];
            default: return k;
        endcase
    endfunction

    function automatic int path_len(input int cls);
        case (cls)
            C_LW:   return 5;
            C_SW, C_R, C_ADDI: return 4;
            C_BEQ, C_J: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [15:0] exp_out(input int s, input int cls, input logic [5:0] f,
                                            input logic z, input logic rst);
        logic       pcen = 0, memw = 0, irw = 0, regw = 0, srca = 0, iord = 0;
        logic       m2r = 0, rdst = 0, ill = 0;
        logic [1:0] srcb = 2'b00, pcsrc = 2'b00;
        logic [2:0] alu = 3'b010;
        case (s)
            0:  begin irw = 1; pcen = 1; srcb = 2'b01; end
            1:  begin srcb = 2'b11; ill = (cls == C_ILL); end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  iord = 1;
            4:  begin m2r = 1; regw = 1; end
            5:  begin iord = 1; memw = 1; end
            6:  begin srca = 1; alu = funct_alu(f); end
            7:  begin rdst = 1; regw = 1; end
            8:  begin srca = 1; alu = 3'b110; pcsrc = 2'b01; pcen = z; end
            9:  begin srca = 1; srcb = 2'b10; end
            10: regw = 1;
            11: begin pcsrc = 2'b10; pcen = 1; end
            default: ;
        endcase
        if (!rst) begin
            pcen = 0; memw = 0; irw = 0; regw = 0; ill = 0;
        end
        return {pcen, memw, irw, regw, srca, srcb, iord, m2r, rdst, pcsrc, alu, ill};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bus_if.pcen, bus_if.memwrite, bus_if.irwrite, bus_if.regwrite,
                bus_if.alusrca, bus_if.alusrcb, bus_if.iord, bus_if.memtoreg,
                bus_if.regdst, bus_if.pcsrc, bus_if.alucontrol, bus_if.illegal};
    endfunction

    // Instruction-level model: step index within the current instruction
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_idx = 0;
        end else begin
            m_idx = m_idx + 1;
            if (m_idx >= path_len(instr_class(bus_if.op, bus_if.funct))) m_idx = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int          cls;
            int          es;
            logic [15:0] ev;
            logic [15:0] av;
            cls = instr_class(bus_if.op, bus_if.funct);
            es  = path_state(cls, m_idx);
            ev  = exp_out(es, cls, bus_if.funct, bus_if.zero, reset);
            av  = dut_vec();
            chk("cycle_state", int'(bus_if.state), es);
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL cycle_outputs: got %b expected %b (state %0d) at %0t",
                         av, ev, es, $time);
            end
        end
    end

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        bus_if.op    = o;
        bus_if.funct = f;
        bus_if.zero  = z;
        rec_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rec_state[k] = int'(bus_if.state);
            rec_out[k]   = dut_vec();
            rec_n        = k + 1;
            @(posedge clk);
            #1;
            if (bus_if.state == 4'd0) break;
        end
    endtask

    int cnt;

    initial begin
        bus_if.op    = 6'b100011;
        bus_if.funct = 6'h20;
        bus_if.zero  = 1'b0;
        #1 reset = 1'b0;
        cmp_en = 1'b1;

        repeat (2) begin
            @(negedge clk);
            chk("rst_state", int'(bus_if.state), 0);
            chk("rst_pcen", int'(bus_if.pcen), 0);
            chk("rst_irwrite", int'(bus_if.irwrite), 0);
        end
        @(posedge clk);
        #1 reset = 1'b1;

        // lw
        run_instr(6'b100011, 6'h00, 1'b0);
        chk("fetch_pcen", int'(rec_out[0][B_PCEN]), 1);
        chk("fetch_irwrite", int'(rec_out[0][B_IRW]), 1);
        chk("fetch_alusrcb", int'(rec_out[0][B_SRCB +: 2]), 1);
        chk("lw_len", rec_n, 5);
        for (int k = 0; k < 5; k++) chk("lw_seq", rec_state[k], k);
        chk("lw_memread_iord", int'(rec_out[3][B_IORD]), 1);
        chk("lw_memwb_regwrite", int'(rec_out[4][B_REGW]), 1);
        chk("lw_memwb_memtoreg", int'(rec_out[4][B_M2R]), 1);
        chk("lw_memwb_regdst", int'(rec_out[4][B_RDST]), 0);
        cnt = 0;
        for (int k = 0; k < rec_n; k++) cnt += int'(rec_out[k][B_MEMW]);
        chk("lw_no_memwrite", cnt, 0);

        // sw
        run_instr(6'b101011, 6'h00, 1'b0);
        chk("sw_len", rec_n, 4);
        chk("sw_last_state", rec_state[3], 5);
        chk("sw_memwrite", int'(rec_out[3][B_MEMW]), 1);
        chk("sw_iord", int'(rec_out[3][B_IORD]), 1);
        cnt = 0;
        for (int k = 0; k < rec_n; k++) cnt += int'(rec_out[k][B_MEMW]) + int'(rec_out[k][B_REGW]);
        chk("sw_strobe_count", cnt, 1);

        // R-type sub, slt, and, or, add
        run_instr(6'b000000, 6'b100010, 1'b0);
        chk("sub_exec_state", rec_state[2], 6);
        chk("sub_alucontrol", int'(rec_out[2][B_ALU +: 3]), 6);
        chk("sub_aluwb_regwrite", int'(rec_out[3][B_REGW]), 1);
        chk("sub_aluwb_regdst", int'(rec_out[3][B_RDST]), 1);
        run_instr(6'b000000, 6'b101010, 1'b0);
        chk("slt_alucontrol", int'(rec_out[2][B_ALU +: 3]), 7);
        run_instr(6'b000000, 6'b100100, 1'b0);
        chk("and_alucontrol", int'(rec_out[2][B_ALU +: 3]), 0);
        run_instr(6'b000000, 6'b100101, 1'b0);
        chk("or_alucontrol", int'(rec_out[2][B_ALU +: 3]), 1);
        run_instr(6'b000000, 6'b100000, 1'b0);
        chk("add_alucontrol", int'(rec_out[2][B_ALU +: 3]), 2);

        // beq taken / not taken
        run_instr(6'b000100, 6'h00, 1'b1);
        chk("beq_len", rec_n, 3);
        chk("beq_state", rec_state[2], 8);
        chk("beq_taken_pcen", int'(rec_out[2][B_PCEN]), 1);
        chk("beq_pcsrc", int'(rec_out[2][B_PCSRC +: 2]), 1);
        chk("beq_alucontrol", int'(rec_out[2][B_ALU +: 3]), 6);
        run_instr(6'b000100, 6'h00, 1'b0);
        chk("beq_nt_pcen", int'(rec_out[2][B_PCEN]), 0);

        // addi, j
        run_instr(6'b001000, 6'h00, 1'b0);
        chk("addi_len", rec_n, 4);
        chk("addi_wb_regwrite", int'(rec_out[3][B_REGW]), 1);
        run_instr(6'b000010, 6'h00, 1'b0);
        chk("j_len", rec_n, 3);
        chk("j_pcsrc", int'(rec_out[2][B_PCSRC +: 2]), 2);

        // illegal opcode and illegal funct
        run_instr(6'b111111, 6'h00, 1'b0);
        chk("ill_len", rec_n, 2);
        chk("ill_fetch", int'(rec_out[0][B_ILL]), 0);
        chk("ill_decode", int'(rec_out[1][B_ILL]), 1);
        run_instr(6'b000000, 6'b000111, 1'b0);
        chk("ill_funct_len", rec_n, 2);
        chk("ill_funct_decode", int'(rec_out[1][B_ILL]), 1);

        // lw interrupted by reset in MEMREAD
        bus_if.op = 6'b100011;
        for (int k = 0; k < 8; k++) begin
            if (bus_if.state == 4'd3) break;
            @(posedge clk);
            #1;
        end
        chk("mid_reach_memread", int'(bus_if.state), 3);
        reset = 1'b0;
        #1;
        chk("mid_async_state", int'(bus_if.state), 0);
        chk("mid_regwrite", int'(bus_if.regwrite), 0);
        chk("mid_pcen", int'(bus_if.pcen), 0);
        @(posedge clk);
        #1;
        chk("mid_held_state", int'(bus_if.state), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_decode", int'(bus_if.state), 1);
        for (int k = 0; k < 8; k++) begin
            if (bus_if.state == 4'd0) break;
            @(posedge clk);
            #1;
        end
        chk("post_rst_complete", int'(bus_if.state), 0);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
